sd_word_serializer: RTL and testbench

SD_WORD_SERIALIZER -- requirements
Module: sd_word_serializer

---
 rtl/sd_word_serializer.sv | 141 ++++++++++++++
 tb/tb_sd_word_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_word_serializer.sv
// ---------------------------------------------------------------------------
// sd_word_serializer
//
// Captures five discrete sampler levels on SAMPLE strobes, tracks which of
// the four DC channels changed since the last word was read out, and on
// request serialises a 14-bit status word MSB first at the BIT_STB rate.
//
// Word layout (bit 13 first on the wire):
//   [13:10] seq   sample counter (wraps 15 -> 0)
//   [9]     s[4]  mode latch (ML1_2)
//   [8:5]   s[3:0] DC4S..DC1S
//   [4:1]   chg   sticky change flags, cleared when a word is loaded
//   [0]     p     parity over the whole word (odd when PAR_ODD = 1)
//
// Ports
//   SIM_CLK   in   block clock, rising edge
//   SIM_RST   in   asynchronous active-high reset
//   SAMPLE    in   one-cycle strobe, captures DC1S..DC4S and ML1_2
//   DC1S..4S  in   discrete sampler channel levels
//   ML1_2     in   mode-latch level
//   REQ       in   word read request, only honoured in IDLE
//   BIT_STB   in   one-cycle bit-time strobe, only honoured in SHIFT
//   SDATA     out  serial data, MSB first, 0 outside SHIFT
//   SBUSY     out  high in LOAD and SHIFT
//   SDONE     out  one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module sd_word_serializer #(
  parameter bit PAR_ODD = 1'b1
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic SAMPLE,
  input  logic DC1S,
  input  logic DC2S,
  input  logic DC3S,
  input  logic DC4S,
  input  logic ML1_2,
  input  logic REQ,
  input  logic BIT_STB,
  output logic SDATA,
  output logic SBUSY,
  output logic SDONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned WORD_W = 14;

  state_t      state;
  logic [4:0]  s;
  logic [3:0]  chg;
  logic [3:0]  seq;
  logic [13:0] shreg;
  logic [3:0]  bit_cnt;

  logic [3:0]  dc;
  logic [3:0]  chg_set;
  logic [12:0] word_body;
  logic        word_par;

  assign dc = {DC4S, DC3S, DC2S, DC1S};

  // Channels whose level differs from the value held before this sample.
  assign chg_set = SAMPLE ? (dc ^ s[3:0]) : 4'b0000;

  // Word is assembled from the registered values, so a SAMPLE landing in
  // the LOAD cycle only affects the next word.
  assign word_body = {seq, s, chg};
  assign word_par  = (^word_body) ^ PAR_ODD;

  // Outputs are pure decodes of registered state, so they are glitch-free
  // and drop to 0 the moment reset forces IDLE.
  assign SDATA = (state == ST_SHIFT) && shreg[13];
  assign SBUSY = (state == ST_LOAD) || (state == ST_SHIFT);
  assign SDONE = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= ST_IDLE;
      s       <= '0;
      chg     <= '0;
      seq     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      // Sampling is independent of the serialiser state.
      if (SAMPLE) begin
        s   <= {ML1_2, dc};
        seq <= seq + 4'd1;
      end

      // LOAD clears the sticky flags, but a change seen in the same cycle
      // must survive into the next word.
      if (state == ST_LOAD) begin
        chg <= chg_set;
      end else begin
        chg <= chg | chg_set;
      end

      unique case (state)
        ST_IDLE: begin
          if (REQ) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          shreg   <= {word_body, word_par};
          bit_cnt <= 4'(WORD_W);
          state   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (BIT_STB) begin
            shreg   <= {shreg[12:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
            if (bit_cnt == 4'd1) begin
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_sd_word_serializer
//
// Scoreboard bench: a small behavioural model of the sampler registers
// predicts each word at the moment the LOAD cycle is driven; the predicted
// word is queued and compared once the 14 serial bits have been collected.
// ---------------------------------------------------------------------------
module tb_sd_word_serializer;

  localparam bit PAR_ODD = 1'b1;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b0;
  logic SAMPLE  = 1'b0;
  logic DC1S    = 1'b0;
  logic DC2S    = 1'b0;
  logic DC3S    = 1'b0;
  logic DC4S    = 1'b0;
  logic ML1_2   = 1'b0;
  logic REQ     = 1'b0;
  logic BIT_STB = 1'b0;
  logic SDATA;
  logic SBUSY;
  logic SDONE;

  sd_word_serializer #(.PAR_ODD(PAR_ODD)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .SAMPLE  (SAMPLE),
    .DC1S    (DC1S),
    .DC2S    (DC2S),
    .DC3S    (DC3S),
    .DC4S    (DC4S),
    .ML1_2   (ML1_2),
    .REQ     (REQ),
    .BIT_STB (BIT_STB),
    .SDATA   (SDATA),
    .SBUSY   (SBUSY),
    .SDONE   (SDONE)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model of the sampler registers.
  logic [4:0] s_m   = '0;
  logic [3:0] chg_m = '0;
  logic [3:0] seq_m = '0;

  logic [13:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic model_sample(input logic [3:0] dc, input logic ml);
    chg_m = chg_m | (dc ^ s_m[3:0]);
    s_m   = {ml, dc};
    seq_m = seq_m + 4'd1;
  endtask

  function automatic logic [13:0] model_word();
    logic [12:0] b;
    b = {seq_m, s_m, chg_m};
    return {b, (^b) ^ PAR_ODD};
  endfunction

  task automatic model_reset();
    s_m   = '0;
    chg_m = '0;
    seq_m = '0;
  endtask

  task automatic set_levels(input logic [3:0] dc, input logic ml);
    {DC4S, DC3S, DC2S, DC1S} = dc;
    ML1_2 = ml;
  endtask

  task automatic drive_sample(input logic [3:0] dc, input logic ml);
    set_levels(dc, ml);
    SAMPLE = 1'b1;
    model_sample(dc, ml);
    step();
    SAMPLE = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    SIM_RST = 1'b1;
    model_reset();
    step();
    step();
    SIM_RST = 1'b0;
  endtask

  // Runs one complete word starting from IDLE. Optional stimulus in the
  // LOAD cycle and random idle gaps (with random samples) between strobes.
  task automatic send_word(input bit hold_req, input bit samp_load,
                           input logic [3:0] dc_load, input bit stb_load,
                           input bit gaps, output logic [13:0] rx);
    logic [3:0] rdc;
    logic       rml;
    logic [13:0] exp_w;
    REQ = 1'b1;
    step();
    check("busy_in_load", SBUSY, 1);
    check("sdata_in_load", SDATA, 0);
    if (!hold_req) REQ = 1'b0;

    // LOAD cycle: the word is built from pre-sample values.
    exp_q.push_back(model_word());
    chg_m = '0;
    if (samp_load) begin
      set_levels(dc_load, ML1_2);
      SAMPLE = 1'b1;
      model_sample(dc_load, ML1_2);
    end
    BIT_STB = stb_load;
    step();
    SAMPLE  = 1'b0;
    BIT_STB = 1'b0;

    rx = '0;
    for (int i = 0; i < 14; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 2) == 0) begin
            rdc = 4'($urandom);
            rml = 1'($urandom);
            set_levels(rdc, rml);
            SAMPLE = 1'b1;
            model_sample(rdc, rml);
          end
          step();
          SAMPLE = 1'b0;
        end
      end
      check("busy_in_shift", SBUSY, 1);
      rx = {rx[12:0], SDATA};
      BIT_STB = 1'b1;
      step();
      BIT_STB = 1'b0;
    end

    check("sdone_after_last", SDONE, 1);
    check("sdata_in_done", SDATA, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      exp_w = exp_q.pop_front();
      check("word", rx, exp_w);
    end
    step();
    check("sdone_one_cycle", SDONE, 0);
    check("idle_not_busy", SBUSY, 0);
  endtask

  logic [13:0] rx;

  initial begin
    // Reset state
    #1;
    SIM_RST = 1'b1;
    #1;
    check("rst_sdata", SDATA, 0);
    check("rst_sbusy", SBUSY, 0);
    check("rst_sdone", SDONE, 0);
    step();
    SIM_RST = 1'b0;
    step();
    check("idle_after_rst", SBUSY, 0);

    // Basic word: ML1_2=1, DC1S=1
    drive_sample(4'b0001, 1'b1);
    send_word(0, 0, 4'b0000, 0, 0, rx);
    check("basic_word_const", rx, 14'b0001_1_0001_0001_1);

    // Follow-up with no new sample: CHG cleared, parity flips
    send_word(0, 0, 4'b0000, 0, 0, rx);
    check("second_word_const", rx, 14'b0001_1_0001_0000_0);

    // DC3S toggles in the LOAD cycle: excluded now, reported next word
    send_word(0, 1, 4'b0101, 0, 0, rx);
    check("load_sample_chg", rx[4:1], 4'b0000);
    send_word(0, 0, 4'b0000, 0, 0, rx);
    check("next_word_const", rx, 14'b0010_1_0101_0100_0);

    // BIT_STB in LOAD is ignored
    drive_sample(4'b1010, 1'b0);
    send_word(0, 0, 4'b0000, 1, 0, rx);

    // Back-to-back words with REQ held high throughout
    drive_sample(4'b0110, 1'b1);
    send_word(1, 0, 4'b0000, 0, 0, rx);
    send_word(1, 0, 4'b0000, 0, 0, rx);
    REQ = 1'b0;
    step();
    step();
    check("idle_after_req_drop", SBUSY, 0);

    // Random traffic with samples arriving mid-shift
    for (int w = 0; w < 6; w++) begin
      drive_sample(4'($urandom), 1'($urandom));
      send_word(0, 1'($urandom), 4'($urandom), 1'($urandom), 1, rx);
    end

    // SEQ wrap after 16 samples
    apply_reset();
    for (int i = 0; i < 16; i++) drive_sample(4'($urandom), 1'($urandom));
    send_word(0, 0, 4'b0000, 0, 0, rx);
    check("seq_wrap", rx[13:10], 4'b0000);

    // Reset in the middle of SHIFT aborts the word
    drive_sample(4'b1000, 1'b0);
    REQ = 1'b1;
    step();
    REQ = 1'b0;
    exp_q.push_back(model_word());
    chg_m = '0;
    step();
    BIT_STB = 1'b1;
    repeat (5) step();
    BIT_STB = 1'b0;
    check("sdata_before_abort", SDATA, exp_q[0][8]);
    #2;
    SIM_RST = 1'b1;
    #1;
    check("abort_sdata", SDATA, 0);
    check("abort_sbusy", SBUSY, 0);
    check("abort_sdone", SDONE, 0);
    void'(exp_q.pop_front());
    model_reset();
    step();
    SIM_RST = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (SDONE) check("no_sdone_after_abort", SDONE, 0);
      step();
    end
    send_word(0, 0, 4'b0000, 0, 0, rx);
    check("seq_after_abort", rx[13:10], 4'b0000);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
